// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-master memory arbiter: bus direction codes,
// default bus widths and the owner-state encoding.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 30;
    localparam int DEF_DATA_W = 32;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic [1:0] OWN_IDLE = 2'd0;
    localparam logic [1:0] OWN_M0   = 2'd1;
    localparam logic [1:0] OWN_M1   = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both master request/grant channels and the shared memory bus.
// The arbiter attaches via the slave modport; masters and memory use master.
interface mem_arbiter_if #(
    parameter int ADDR_W = mem_arb_pkg::DEF_ADDR_W,
    parameter int DATA_W = mem_arb_pkg::DEF_DATA_W
);
    logic              m0_req;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_rw;
    logic [DATA_W-1:0] m0_wr_data;
    logic              m0_gnt;
    logic [DATA_W-1:0] m0_rd_data;

    logic              m1_req;
    logic [ADDR_W-1:0] m1_addr;
    logic              m1_rw;
    logic [DATA_W-1:0] m1_wr_data;
    logic              m1_gnt;
    logic [DATA_W-1:0] m1_rd_data;

    logic [ADDR_W-1:0] memory_addr;
    logic              memory_as_;
    logic              memory_rw;
    logic [DATA_W-1:0] memory_wr_data;
    logic [DATA_W-1:0] memory_rd_data;

    modport slave (
        input  m0_req, m0_addr, m0_rw, m0_wr_data,
        output m0_gnt, m0_rd_data,
        input  m1_req, m1_addr, m1_rw, m1_wr_data,
        output m1_gnt, m1_rd_data,
        output memory_addr, memory_as_, memory_rw, memory_wr_data,
        input  memory_rd_data
    );

    modport master (
        output m0_req, m0_addr, m0_rw, m0_wr_data,
        input  m0_gnt, m0_rd_data,
        output m1_req, m1_addr, m1_rw, m1_wr_data,
        input  m1_gnt, m1_rd_data,
        input  memory_addr, memory_as_, memory_rw, memory_wr_data,
        output memory_rd_data
    );
endinterface

// File: rtl/mem_arb_next_owner.sv
// Combinational next-owner decision: keep the owner while it requests unless
// its burst is exhausted under contention; ties go to the non-last owner.
module mem_arb_next_owner
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic [1:0] owner_q,
    input  logic       m0_req,
    input  logic       m1_req,
    input  logic [3:0] burst_cnt_q,
    input  logic       last_owner_q,
    output logic [1:0] next_owner
);
    localparam logic [3:0] LIMIT = 4'(BURST_MAX - 1);

    logic w_own_req;
    logic w_oth_req;

    always_comb begin
        w_own_req  = 1'b0;
        w_oth_req  = 1'b0;
        next_owner = OWN_IDLE;
        if (owner_q == OWN_M0) begin
            w_own_req = m0_req;
            w_oth_req = m1_req;
        end else if (owner_q == OWN_M1) begin
            w_own_req = m1_req;
            w_oth_req = m0_req;
        end

        if (w_own_req) begin
            if (!w_oth_req || (burst_cnt_q < LIMIT))
                next_owner = owner_q;
            else
                next_owner = (owner_q == OWN_M0) ? OWN_M1 : OWN_M0;
        end else if (m0_req && m1_req) begin
            // Tie: the master that did not own the bus last wins
            next_owner = last_owner_q ? OWN_M0 : OWN_M1;
        end else if (m0_req) begin
            next_owner = OWN_M0;
        end else if (m1_req) begin
            next_owner = OWN_M1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master memory arbiter with bounded bursts and registered grants.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie breaking (default: master 0 wins ties).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int BURST_MAX = 4,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);
    logic [1:0]        r_owner;
    logic [1:0]        w_next_owner;
    logic [3:0]        r_burst_cnt;
    logic              w_last_owner;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_xfer0;
    logic              w_xfer1;
    logic [ADDR_W-1:0] w_addr;
    logic              w_rw;
    logic [DATA_W-1:0] w_wr_data;

    assign w_gnt0  = (r_owner == OWN_M0);
    assign w_gnt1  = (r_owner == OWN_M1);
    assign w_xfer0 = w_gnt0 & bus.m0_req;
    assign w_xfer1 = w_gnt1 & bus.m1_req;

    mem_arb_next_owner #(.BURST_MAX(BURST_MAX)) u_next_owner (
        .owner_q      (r_owner),
        .m0_req       (bus.m0_req),
        .m1_req       (bus.m1_req),
        .burst_cnt_q  (r_burst_cnt),
        .last_owner_q (w_last_owner),
        .next_owner   (w_next_owner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_IDLE;
            r_burst_cnt <= 4'd0;
        end else begin
            r_owner <= w_next_owner;
            if ((w_next_owner != r_owner) || (w_next_owner == OWN_IDLE))
                r_burst_cnt <= 4'd0;
            else if ((w_xfer0 || w_xfer1) && (r_burst_cnt != 4'hF))
                r_burst_cnt <= r_burst_cnt + 4'd1;
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last_owner;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_last_owner <= 1'b0;
        else if (w_next_owner == OWN_M0)
            r_last_owner <= 1'b0;
        else if (w_next_owner == OWN_M1)
            r_last_owner <= 1'b1;
    end

    assign w_last_owner = r_last_owner;
`else
    // Pretending master 1 always owned last makes every tie resolve to master 0
    assign w_last_owner = 1'b1;
`endif

    always_comb begin
        w_addr    = '0;
        w_rw      = READ;
        w_wr_data = '0;
        if (w_xfer0) begin
            w_addr    = bus.m0_addr;
            w_rw      = bus.m0_rw;
            w_wr_data = bus.m0_wr_data;
        end else if (w_xfer1) begin
            w_addr    = bus.m1_addr;
            w_rw      = bus.m1_rw;
            w_wr_data = bus.m1_wr_data;
        end
    end

    assign bus.memory_as_     = ~(w_xfer0 | w_xfer1);
    assign bus.memory_addr    = w_addr;
    assign bus.memory_rw      = w_rw;
    assign bus.memory_wr_data = w_wr_data;

    assign bus.m0_gnt     = w_gnt0;
    assign bus.m1_gnt     = w_gnt1;
    assign bus.m0_rd_data = w_gnt0 ? bus.memory_rd_data : '0;
    assign bus.m1_rd_data = w_gnt1 ? bus.memory_rd_data : '0;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master arbiter and sequencer in front of the shared word memory (30-bit address, 32-bit data, active-low select, rw=1 read).
- Master 0 is the load/store unit; master 1 is instruction fetch.
- Grants one master per cycle, drives the memory select/rw/address/write-data lines, and returns read data.
- Bounds consecutive grants to one master so neither starves.

Parameters:
- BURST_MAX, 4: max consecutive transfer cycles to one owner while the other master requests (legal 1..15).
- ADDR_W, 30: address width.
- DATA_W, 32: data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- m0_req  input  1  master 0 request; held until transfer done.
- m0_addr  input  ADDR_W  master 0 address.
- m0_rw  input  1  1=read, 0=write.
- m0_wr_data  input  DATA_W  master 0 write data.
- m0_gnt  output  1  registered grant; transfer occurs in any cycle with m0_gnt and m0_req both high.
- m0_rd_data  output  DATA_W  memory_rd_data while m0_gnt=1, else 0.
- m1_req, m1_addr, m1_rw, m1_wr_data, m1_gnt, m1_rd_data: same directions, widths and meanings, for master 1.
- memory_addr  output  ADDR_W  to memory.
- memory_as_  output  1  active-low select to memory.
- memory_rw  output  1  to memory; 1=read.
- memory_wr_data  output  DATA_W  to memory.
- memory_rd_data  input  DATA_W  combinational read data from memory.

Behaviour:
- State owner_q ∈ {IDLE, OWN0, OWN1}; mN_gnt = (owner_q==OWNN), decoded from register only (no combinational req→gnt path).
- burst_cnt_q, 4 bits.
- Reset (asynchronous):
  - owner_q=IDLE, burst_cnt_q=0, both gnt=0.
  - memory_as_=1, memory_rw=1, memory_addr=0, memory_wr_data=0, both rd_data=0.
- Memory bus:
  - When the owner's req is high: memory_as_=0; addr/rw/wr_data muxed from the owner.
  - Otherwise (IDLE, or owner dropped req): memory_as_=1, rw=1, addr=0, wr_data=0.
- Latency:
  - req rises at edge T with owner_q=IDLE → gnt high in cycle T+1, and the transfer happens in T+1.
  - Read data is valid combinationally during the gnt cycle.
  - A write commits at the edge ending the gnt cycle.
- Master rule: hold addr/rw/wr_data stable while req is high. Each gnt&req cycle is one transfer. Drop req after the last transfer.
- Next owner, each edge:
  - No req → IDLE.
  - Owner req high, and (other req low or burst_cnt_q < BURST_MAX-1) → keep owner.
  - Otherwise → the other requesting master.
  - From IDLE, or when the owner drops req: the single requester wins. A tie resolves per the tie rule under Optional Feature.
- burst_cnt_q:
  - Clears on any owner change and in IDLE.
  - Increments per transfer of the same owner; saturates at 15.
- Boundaries:
  - Owner drops req while granted: no access that cycle (as_=1); owner released at the next edge.
  - BURST_MAX=1: strict alternation under contention.
  - Both masters same address, write then read: the read sees the new data (write committed first).
  - rst asserted mid-burst: gnt and as_ drop asynchronously; an in-flight write is not committed.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - last_owner_q register (reset 0 = master 0), updated on every grant.
  - Ties from IDLE/release go to the master that was not last owner.
- Undefined:
  - No last_owner_q.
  - Ties always go to master 0 (fixed priority).
  - Starvation is still bounded by BURST_MAX.

Decomposition:
- Package mem_arb_pkg holds:
  - READ=1, WRITE=0.
  - ADDR_W, DATA_W defaults.
  - owner encoding OWN_IDLE=2'd0, OWN_M0=2'd1, OWN_M1=2'd2.
- One sub-module: mem_arb_next_owner. Combinational; inputs owner_q, both reqs, burst_cnt_q, last_owner_q; output next owner.
- Registers, bus muxing and rd_data gating stay in mem_arbiter.

Test Plan:
- Reset: hold rst 3 cycles with both req=1 → gnt=0, memory_as_=1, memory_rw=1, addr=0 throughout. Release → m0_gnt=1 next cycle.
- Single read: m1_req=1, m1_addr=0x10, m1_rw=1 at T → cycle T+1 has m1_gnt=1, memory_addr=0x10, memory_as_=0, m1_rd_data=memory_rd_data, m0_rd_data=0.
- Write then release: m0 writes 0x20 ← 0xDEADBEEF for one cycle, then drops req → memory_rw=0 and memory_wr_data=0xDEADBEEF during gnt. Next cycle IDLE, as_=1. A m1 read of 0x20 returns 0xDEADBEEF.
- Contention, BURST_MAX=4: both req held 20 cycles → grants m0×4, m1×4, m0×4…; neither master waits more than 4 cycles.
- Tie after release (m0 last owner, both req rise together from IDLE) → macro defined: m1 granted; undefined: m0 granted.
- Reset mid-burst: assert rst during an m0 write gnt cycle → m0_gnt=0 and memory_as_=1 before the edge; memory contents unchanged.
